// File: rtl/pio_chaos_out.sv
// Avalon-MM output port feeding the chaos core: a shadow register is staged by writes
// and handed over through a valid/ready handshake followed by a programmable hold period.
module pio_chaos_out (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  out_port,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {StIdle, StPresent, StHold} state_e;

   state_e      state;
   logic [7:0]  shadow;
   logic [7:0]  shadow_d;
   logic [7:0]  hold;
   logic [7:0]  counter;
   logic        pending;
   logic        wr;
   logic        data_wr;
   logic        busy;
   logic [31:0] rd_next;
   logic        unused_wd;

   assign unused_wd = ^writedata[31:8];
   assign wr        = chipselect & ~write_n;
   assign busy      = (state != StIdle);

   always_comb begin
      shadow_d = shadow;
      data_wr  = 1'b0;
      if (wr) begin
         case (address)
            3'd0: begin
               shadow_d = writedata[7:0];
               data_wr  = 1'b1;
            end
            3'd4: begin
               shadow_d = shadow | writedata[7:0];
               data_wr  = 1'b1;
            end
            3'd5: begin
               shadow_d = shadow & ~writedata[7:0];
               data_wr  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (address)
         3'd0:    rd_next = {24'b0, shadow};
         3'd1:    rd_next = {30'b0, pending, busy};
         3'd2:    rd_next = {24'b0, hold};
         default: rd_next = 32'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata  <= 32'b0;
         out_port  <= 8'b0;
         out_valid <= 1'b0;
         shadow    <= 8'b0;
         pending   <= 1'b0;
         hold      <= 8'd1;
         counter   <= 8'b0;
         state     <= StIdle;
      end else begin
         readdata <= rd_next;
         shadow   <= shadow_d;
         if (wr && address == 3'd2) hold <= writedata[7:0];

         // A write in the load cycle wins over the clear, giving a second transfer.
         if (data_wr) pending <= 1'b1;
         else if (state == StIdle && pending) pending <= 1'b0;

         case (state)
            StIdle: begin
               if (pending) begin
                  out_port  <= shadow;
                  out_valid <= 1'b1;
                  state     <= StPresent;
               end
            end
            StPresent: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  counter   <= (hold == 8'd0) ? 8'd1 : hold;
                  state     <= StHold;
               end
            end
            StHold: begin
               counter <= counter - 8'd1;
               if (counter == 8'd1) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/pio_chaos_out.md
PIO_CHAOS_OUT -- requirements
Module: pio_chaos_out

Interface
REQ-001 Parameters: none; data width fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 address  input  3  Avalon-MM slave register select.
REQ-005 chipselect  input  1  slave select, qualifies writes.
REQ-006 write_n  input  1  active-low write strobe.
REQ-007 writedata  input  32  write data; only [7:0] used.
REQ-008 readdata  output  32  registered read data; [31:8] always 0.
REQ-009 out_port  output  8  committed output value to the chaos-core input.
REQ-010 out_valid  output  1  high while a new out_port value awaits acceptance.
REQ-011 out_ready  input  1  consumer accepts the presented value.

Function
REQ-012 Write strobe: wr = chipselect & ~write_n; a write is effective only in cycles where wr=1.
REQ-013 Register map:
- 0 DATA: W sets shadow <= writedata[7:0]; R returns shadow.
- 1 STATUS: R returns {30'b0, pending, busy}; writes ignored.
- 2 HOLD: 8-bit R/W.
- 4 OUTSET: W sets shadow <= shadow | writedata[7:0]; R returns 0.
- 5 OUTCLEAR: W sets shadow <= shadow & ~writedata[7:0]; R returns 0.
- 3, 6, 7: R returns 0; writes ignored.
REQ-014 readdata SHALL be registered every cycle from address, independent of chipselect; read latency is 1 cycle.
REQ-015 Any effective write to DATA, OUTSET or OUTCLEAR SHALL set pending in the following cycle.
REQ-016 FSM states: IDLE, PRESENT, HOLD; busy = (state != IDLE).
REQ-017 In IDLE with pending=1, the block SHALL:
- load out_port <= registered shadow;
- clear pending;
- set out_valid;
- enter PRESENT.
REQ-018 In PRESENT, out_valid SHALL stay 1 and out_port SHALL stay stable until out_ready=1 is sampled. On that edge:
- out_valid <= 0;
- hold counter <= HOLD, with HOLD=0 treated as 1;
- enter HOLD.
REQ-019 In HOLD, the counter SHALL decrement each cycle; when the counter equals 1 the FSM SHALL return to IDLE. HOLD=N therefore gives exactly N cycles in the HOLD state.
REQ-020 out_port SHALL change only on the IDLE->PRESENT transition.
REQ-021 Writes during PRESENT or HOLD SHALL update shadow and set pending only. The new value is presented after the FSM returns to IDLE. Multiple such writes coalesce into one transfer carrying the final shadow.
REQ-022 A write in the same cycle as an IDLE load SHALL leave pending=1: set beats clear. out_port takes the pre-write shadow; the post-write value follows as a second transfer.
REQ-023 Writes to HOLD SHALL take effect on the next load of the hold counter; a HOLD period already in progress is unaffected.
REQ-024 out_ready while not in PRESENT SHALL be ignored.

Reset
REQ-025 While reset_n=0 at a rising clk edge, the block SHALL set:
- readdata=0, out_port=0, out_valid=0;
- shadow=0, pending=0;
- HOLD=1, counter=0;
- state=IDLE.
REQ-026 Reset asserted mid-transfer (PRESENT or HOLD) SHALL abort the transfer: no further out_valid until a new write occurs after reset is released.

Verification
REQ-027 Write DATA=0x5A, out_ready=1 held -> pending=1 next cycle; out_port=0x5A with out_valid=1 one cycle later; out_valid low after 1 cycle; STATUS reads 0 once HOLD=1 has elapsed.
REQ-028 DATA=0xF0, then OUTSET=0x0F, then OUTCLEAR=0x81, each completed before the next -> out_port sequence 0xF0, 0xFF, 0x7E; DATA readback=0x7E.
REQ-029 HOLD=4, write DATA=0x11, out_ready asserted 3 cycles after out_valid rises -> out_valid stays high 3 cycles with 0x11 stable; busy stays high for exactly 4 cycles after acceptance.
REQ-030 During PRESENT (out_ready=0), write DATA=0x22, then DATA=0x33 -> out_port stays at its old value; after acceptance and HOLD, exactly one further transfer with out_port=0x33.
REQ-031 Write DATA in the exact IDLE load cycle (pending already set, shadow=0xA0, new write 0x0B) -> first transfer 0xA0, second transfer 0x0B.
REQ-032 Assert reset_n=0 for 1 cycle during PRESENT with HOLD=7 -> next cycle: out_valid=0, out_port=0, HOLD reads 1, STATUS reads 0.
